// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the exec_ctrl slice.
//   DATA_W / ADDR_W : default datapath and register-address widths
//   op_t            : opcode encodings (0x0..0xA legal, 0xB..0xF illegal)
//   state_t         : controller FSM encodings
//   instr_t         : instruction word layout {op, rd, ra, rb, spare}
//   IMM_*           : imm6 position, which overlaps rb and spare
package exec_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned IMM_W   = 6;
  localparam int unsigned IMM_MSB = 5;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_NOT = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_MOV = 4'h9,
    OP_LDI = 4'hA
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Instruction word; bit 15 is the MSB of op.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [2:0]      rd;
    logic [2:0]      ra;
    logic [2:0]      rb;
    logic [2:0]      spare;
  } instr_t;

  // Opcodes above LDI have no defined behaviour.
  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op > OP_LDI);
  endfunction

  // Every legal opcode except NOP produces a register write.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && !op_is_illegal(op);
  endfunction

endpackage

// File: rtl/alu16.sv
// alu16: combinational ALU for exec_ctrl.
//   op     : opcode (exec_pkg::op_t encoding)
//   a, b   : operands captured from the register file
//   imm    : imm6 field, sign-extended for LDI
//   result : operation result (0 for NOP / illegal)
//   zero   : result == 0
//   carry  : carry-out / borrow / shifted-out bit, 0 for other ops
module alu16 #(
  parameter int unsigned DATA_W = exec_pkg::DATA_W
) (
  input  logic [exec_pkg::OP_W-1:0]  op,
  input  logic [DATA_W-1:0]          a,
  input  logic [DATA_W-1:0]          b,
  input  logic [exec_pkg::IMM_W-1:0] imm,
  output logic [DATA_W-1:0]          result,
  output logic                       zero,
  output logic                       carry
);

  import exec_pkg::*;

  logic [DATA_W:0] sum;

  // Operation select; the extra sum bit carries ADD's carry-out.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    sum    = '0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      OP_MOV: result = a;
      OP_LDI: result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: non-pipelined single-instruction executor, IDLE->READ->EXEC->WB.
//   clk, reset           : clock, synchronous active-low reset
//   instr_valid, instr   : instruction offer; accepted when instr_ready
//   instr_ready          : high in IDLE while reset is released
//   rd_addr_a, rd_addr_b : register-file read addresses (ra, rb)
//   d_out_a, d_out_b     : register-file read data
//   wr, wr_addr, d_in    : register-file write port, one-cycle pulse in WB
//   zero, carry          : flags of the last writing ALU op
//   busy, done, err      : not-IDLE, WB pulse, WB pulse for illegal opcode
module exec_ctrl #(
  parameter int unsigned DATA_W = exec_pkg::DATA_W,
  parameter int unsigned ADDR_W = exec_pkg::ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          instr_valid,
  input  logic [exec_pkg::INSTR_W-1:0]  instr,
  output logic                          instr_ready,
  output logic [ADDR_W-1:0]             rd_addr_a,
  output logic [ADDR_W-1:0]             rd_addr_b,
  input  logic [DATA_W-1:0]             d_out_a,
  input  logic [DATA_W-1:0]             d_out_b,
  output logic                          wr,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             d_in,
  output logic                          zero,
  output logic                          carry,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  import exec_pkg::*;

  state_t            state;
  instr_t            f;
  logic [OP_W-1:0]   ir_op;
  logic [2:0]        ir_rd;
  logic [IMM_W-1:0]  ir_imm;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;

  assign f = instr_t'(instr);

  // Ready is gated by reset directly so it is low throughout reset.
  assign instr_ready = (state == ST_IDLE) && reset;
  assign busy        = (state != ST_IDLE);

  alu16 #(.DATA_W(DATA_W)) u_alu (
    .op     (ir_op),
    .a      (opa),
    .b      (opb),
    .imm    (ir_imm),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  // Controller FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ir_op     <= '0;
      ir_rd     <= '0;
      ir_imm    <= '0;
      opa       <= '0;
      opb       <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      wr        <= 1'b0;
      wr_addr   <= '0;
      d_in      <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir_op     <= f.op;
            ir_rd     <= f.rd;
            ir_imm    <= f[IMM_MSB:IMM_LSB];
            rd_addr_a <= ADDR_W'(f.ra);
            rd_addr_b <= ADDR_W'(f.rb);
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          // Operands are captured here, so rd may alias ra/rb safely.
          opa   <= d_out_a;
          opb   <= d_out_b;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          done  <= 1'b1;
          err   <= op_is_illegal(ir_op);
          state <= ST_WB;
          if (op_writes(ir_op)) begin
            wr      <= 1'b1;
            wr_addr <= ADDR_W'(ir_rd);
            d_in    <= alu_result;
            zero    <= alu_zero;
            carry   <= alu_carry;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed self-checking bench for exec_ctrl with a behavioural
// 8-entry register file attached to its read/write ports.
module tb_exec_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          reset;
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] d_out_a;
  logic [DW-1:0] d_out_b;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] d_in;
  logic          zero;
  logic          carry;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] rf [0:7];

  int n_tests = 0;
  int n_fail  = 0;

  exec_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .d_out_a     (d_out_a),
    .d_out_b     (d_out_b),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .zero        (zero),
    .carry       (carry),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];

  always @(posedge clk) begin
    if (wr) rf[wr_addr] <= d_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer one instruction in IDLE; returns at the READ-cycle sample point.
  task automatic issue(input logic [15:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    chk("ready_in_idle", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int acc_cnt;
  int acc_t [0:3];
  int rdy_busy_bad;
  int wr_cnt;

  initial begin
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    tick();
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_wr",    32'(wr),          32'd0);
    chk("rst_waddr", 32'(wr_addr),     32'd0);
    chk("rst_d_in",  32'(d_in),        32'd0);
    chk("rst_zero",  32'(zero),        32'd0);
    chk("rst_carry", 32'(carry),       32'd0);
    chk("rst_done",  32'(done),        32'd0);
    chk("rst_err",   32'(err),         32'd0);
    chk("rst_rda",   32'(rd_addr_a),   32'd0);
    chk("rst_rdb",   32'(rd_addr_b),   32'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_release", 32'(instr_ready), 32'd1);

    // LDI r1,#-1
    issue(16'hA23F);
    chk("ldi_read_rda",  32'(rd_addr_a),   32'd0);
    chk("ldi_read_rdb",  32'(rd_addr_b),   32'd7);
    chk("ldi_busy",      32'(busy),        32'd1);
    chk("ldi_not_ready", 32'(instr_ready), 32'd0);
    tick();
    chk("ldi_exec_wr",   32'(wr),          32'd0);
    tick();
    chk("ldi_wb_wr",     32'(wr),          32'd1);
    chk("ldi_wb_waddr",  32'(wr_addr),     32'd1);
    chk("ldi_wb_d_in",   32'(d_in),        32'hFFFF);
    chk("ldi_wb_zero",   32'(zero),        32'd0);
    chk("ldi_wb_carry",  32'(carry),       32'd0);
    chk("ldi_wb_done",   32'(done),        32'd1);
    chk("ldi_wb_err",    32'(err),         32'd0);
    chk("ldi_rf_before", 32'(rf[1]),       32'd0);
    tick();
    chk("ldi_idle_wr",   32'(wr),          32'd0);
    chk("ldi_idle_done", 32'(done),        32'd0);
    chk("ldi_rf_after",  32'(rf[1]),       32'hFFFF);

    // ADD r5,r3,r7
    rf[3] = 16'hCDEF; rf[7] = 16'h3210;
    issue(16'h1AF8);
    tick(); tick();
    chk("add1_d_in",  32'(d_in),    32'hFFFF);
    chk("add1_waddr", 32'(wr_addr), 32'd5);
    chk("add1_carry", 32'(carry),   32'd0);
    chk("add1_zero",  32'(zero),    32'd0);
    tick();
    rf[3] = 16'h8000; rf[7] = 16'h8000;
    issue(16'h1AF8);
    tick(); tick();
    chk("add2_d_in",  32'(d_in),  32'h0000);
    chk("add2_carry", 32'(carry), 32'd1);
    chk("add2_zero",  32'(zero),  32'd1);
    chk("add2_wr",    32'(wr),    32'd1);
    tick();

    // SUB r0,r1,r1 then SUB r2,r0,r1
    rf[1] = 16'h4567;
    issue(16'h2048);
    tick(); tick();
    chk("sub1_d_in",  32'(d_in),    32'h0000);
    chk("sub1_zero",  32'(zero),    32'd1);
    chk("sub1_carry", 32'(carry),   32'd0);
    chk("sub1_waddr", 32'(wr_addr), 32'd0);
    tick();
    rf[0] = 16'h0000; rf[1] = 16'h0001;
    issue(16'h2408);
    tick(); tick();
    chk("sub2_d_in",  32'(d_in),    32'hFFFF);
    chk("sub2_carry", 32'(carry),   32'd1);
    chk("sub2_zero",  32'(zero),    32'd0);
    chk("sub2_waddr", 32'(wr_addr), 32'd2);
    tick();

    // NOT / XOR / SHL / SHR on r3 = 0x8001, rd = r4 or r6
    rf[3] = 16'h8001;
    issue(16'h6CC0);
    tick(); tick();
    chk("not_d_in",  32'(d_in),  32'h7FFE);
    chk("not_carry", 32'(carry), 32'd0);
    tick();
    issue(16'h58D8);
    tick(); tick();
    chk("xor_d_in", 32'(d_in), 32'h0000);
    chk("xor_zero", 32'(zero), 32'd1);
    tick();
    issue(16'h78C0);
    tick(); tick();
    chk("shl_d_in",  32'(d_in),  32'h0002);
    chk("shl_carry", 32'(carry), 32'd1);
    chk("shl_zero",  32'(zero),  32'd0);
    tick();
    issue(16'h88C0);
    tick(); tick();
    chk("shr_d_in",  32'(d_in),  32'h4000);
    chk("shr_carry", 32'(carry), 32'd1);
    tick();

    // Illegal opcode: flags stay zero=0 carry=1
    issue(16'hF000);
    tick(); tick();
    chk("ill_err",   32'(err),   32'd1);
    chk("ill_done",  32'(done),  32'd1);
    chk("ill_wr",    32'(wr),    32'd0);
    chk("ill_zero",  32'(zero),  32'd0);
    chk("ill_carry", 32'(carry), 32'd1);
    tick();
    chk("ill_err_pulse",  32'(err),  32'd0);
    chk("ill_done_pulse", 32'(done), 32'd0);

    // NOP
    issue(16'h0000);
    tick(); tick();
    chk("nop_done",  32'(done),  32'd1);
    chk("nop_err",   32'(err),   32'd0);
    chk("nop_wr",    32'(wr),    32'd0);
    chk("nop_carry", 32'(carry), 32'd1);
    tick();

    // instr_valid held for 12 cycles with LDI r2,#5
    acc_cnt = 0; rdy_busy_bad = 0; wr_cnt = 0;
    instr = 16'hA405;
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (instr_ready) begin
        if (acc_cnt < 4) acc_t[acc_cnt] = c;
        acc_cnt++;
      end
      if (busy && instr_ready) rdy_busy_bad++;
      if (wr) wr_cnt++;
      tick();
    end
    instr_valid = 1'b0;
    chk("tp_accepts",    32'(acc_cnt),      32'd3);
    chk("tp_gap1",       32'(acc_t[1] - acc_t[0]), 32'd4);
    chk("tp_gap2",       32'(acc_t[2] - acc_t[1]), 32'd4);
    chk("tp_ready_busy", 32'(rdy_busy_bad), 32'd0);
    chk("tp_writes",     32'(wr_cnt),       32'd3);
    chk("tp_rf2",        32'(rf[2]),        32'h0005);

    // Reset asserted during EXEC of ADD r5,r3,r7
    rf[3] = 16'h1234; rf[7] = 16'h1111; rf[5] = 16'h0000;
    issue(16'h1AF8);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_wr",    32'(wr),          32'd0);
    chk("mid_waddr", 32'(wr_addr),     32'd0);
    chk("mid_d_in",  32'(d_in),        32'd0);
    chk("mid_zero",  32'(zero),        32'd0);
    chk("mid_carry", 32'(carry),       32'd0);
    chk("mid_done",  32'(done),        32'd0);
    chk("mid_err",   32'(err),         32'd0);
    chk("mid_busy",  32'(busy),        32'd0);
    chk("mid_rda",   32'(rd_addr_a),   32'd0);
    chk("mid_rdb",   32'(rd_addr_b),   32'd0);
    chk("mid_ready", 32'(instr_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_ready_release", 32'(instr_ready), 32'd1);
    wr_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wr) wr_cnt++;
    end
    chk("mid_no_wr",  32'(wr_cnt), 32'd0);
    chk("mid_rf5",    32'(rf[5]),  32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register/datapath width.
REQ-002 SHALL have parameter ADDR_W, default 3, register-file address width (8 registers).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port instr_valid  in  1  instruction offered.
REQ-006 SHALL have port instr  in  16  fields {op[15:12], rd[11:9], ra[8:6], rb[5:3], spare[2:0]}, with imm6 = instr[5:0].
REQ-007 SHALL have port instr_ready  out  1  block can accept an instruction.
REQ-008 SHALL have ports rd_addr_a and rd_addr_b  out  ADDR_W each  register-file read addresses.
REQ-009 SHALL have ports d_out_a and d_out_b  in  DATA_W each  register-file read data (combinational from the addresses).
REQ-010 SHALL have ports wr  out  1, wr_addr  out  ADDR_W, and d_in  out  DATA_W  register-file write port.
REQ-011 SHALL have ports zero and carry  out  1 each  flags of the last executed ALU op.
REQ-012 SHALL have ports busy, done and err  out  1 each  busy = not IDLE; done = one-cycle pulse in WB; err = one-cycle pulse in WB for an illegal opcode.

Function
REQ-013 SHALL implement FSM IDLE->READ->EXEC->WB->IDLE, advancing one state per clock.
REQ-014 SHALL assert instr_ready only in IDLE with reset high, and SHALL accept on instr_valid&&instr_ready, latching instr and moving to READ.
REQ-015 SHALL hold rd_addr_a=ra and rd_addr_b=rb for the READ cycle, capture d_out_a/d_out_b at the end of READ, and hold the last addresses in every other state.
REQ-016 SHALL, in EXEC, compute the result and register it together with the flags at the EXEC->WB edge.
REQ-017 SHALL, in WB, drive wr=1, wr_addr=rd and d_in=result for exactly one cycle, except NOP and illegal opcodes, which drive wr=0.
REQ-018 SHALL decode opcodes as 0 NOP, 1 ADD a+b, 2 SUB a-b, 3 AND, 4 OR, 5 XOR, 6 NOT a, 7 SHL a<<1, 8 SHR a>>1 (logical), 9 MOV a, A LDI sext(imm6); B-F are illegal.
REQ-019 SHALL set carry to: bit DATA_W of the sum for ADD; 1 on borrow (a<b unsigned) for SUB; shifted-out bit for SHL/SHR; 0 for all other writing ops.
REQ-020 SHALL set zero = (result==0) for every writing op, and SHALL leave both flags unchanged for NOP and illegal opcodes.
REQ-021 SHALL achieve a latency of accept edge +3 edges to the write edge, with throughput of one instruction per 4 cycles and no pipelining.
REQ-022 SHALL ignore instr_valid while busy, and SHALL NOT write the same instruction twice.
REQ-023 SHALL permit rd==ra==rb, since operands are captured before the write.

Reset
REQ-024 SHALL, on clk edge with reset low, go to IDLE and clear wr, wr_addr, rd_addr_a, rd_addr_b, d_in, zero, carry, done and err to 0, with busy=0.
REQ-025 SHALL, on reset mid-operation, discard the in-flight instruction and issue no wr pulse.
REQ-026 SHALL drive instr_ready=0 while reset is low and 1 in the first cycle after release.

Structure
REQ-027 SHALL place opcode constants, FSM state encodings, instr field positions, DATA_W and ADDR_W in shared package exec_pkg.
REQ-028 SHALL implement the ALU as one combinational sub-module alu16 (op, a, b, imm -> result, zero, carry), while the FSM and registers stay in exec_ctrl.

Verification
REQ-029 SHALL verify: instr=16'hA23F (LDI r1,#-1) -> wr=1 in WB with wr_addr=1, d_in=16'hFFFF, zero=0, carry=0, on the 3rd edge after accept.
REQ-030 SHALL verify: r3=16'hCDEF, r7=16'h3210, instr=16'h1AF8 (ADD r5,r3,r7) -> d_in=16'hFFFF, wr_addr=5, carry=0, and with r3=r7=16'h8000 -> d_in=16'h0000, carry=1, zero=1.
REQ-031 SHALL verify: r1=16'h4567, instr=16'h2048 (SUB r0,r1,r1) -> d_in=0, zero=1, carry=0, and with ra=0 (value 0), rb=1 (value 1) -> d_in=16'hFFFF, carry=1.
REQ-032 SHALL verify: instr_valid held high for 12 cycles -> exactly 3 accepts, 4 cycles apart, and instr_ready low while busy.
REQ-033 SHALL verify: reset driven low during EXEC -> no wr pulse, all outputs 0 next edge, instr_ready=1 one cycle after release.
REQ-034 SHALL verify: instr=16'hF000 -> err=1 and done=1 for one cycle in WB, wr=0, flags unchanged.
